mc_ctrl_unit: RTL and testbench
===============================

Name: mc_ctrl_unit

Overview:
Multi-cycle sequencer for the MIPS datapath. It holds one FSM that steps each instruction through fetch, decode, execute, memory and writeback, and drives every datapath select and enable in each state. Memory fetches and accesses use a mem_re/mem_we + mem_ready handshake with variable latency. It sits between the instruction/data memory port and the datapath and replaces the single-cycle combinational control.

Parameters:
TIMEOUT, 16, maximum cycles to wait for mem_ready in any wait state before aborting; 0 disables the timeout
ALU_W, 4, width of alu_ctrl

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
opcode  in  6  instr[31:26] from the instruction register
funct  in  6  instr[5:0] from the instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current read/write this cycle
mem_re  out  1  memory read request
mem_we  out  1  memory write request
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
ir_we  out  1  instruction register load
pc_we  out  1  PC load
pc_src  out  2  next-PC select: 00 = ALU, 01 = ALUOut (BTA), 10 = JTA, 11 = rs (JR)
alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs
alu_src_b  out  2  ALU B select: 00 = rt, 01 = 4, 10 = sext_imm, 11 = sext_imm<<2
alu_ctrl  out  ALU_W  ALU operation
reg_dst  out  1  RF write address: 0 = rt, 1 = rd
dm2reg  out  1  RF write data from memory
we_reg  out  1  RF write enable
jal  out  1  RF write to $31 with PC+4
jr  out  1  jump-register indicator
instr_done  out  1  one-cycle pulse on the final cycle of each instruction
mem_err  out  1  one-cycle pulse on timeout abort
illegal  out  1  sticky illegal-instruction flag

Behaviour:
- All outputs are Moore-decoded from state, except that pc_we, ir_we and the exit from a wait state are qualified by mem_ready or zero.
- While rst=1, all outputs are 0, state=FETCH and the timeout counter is cleared. rst wins over any simultaneous event, including in the middle of an instruction.
- FETCH: mem_re=1, iord=0, src_a=0, src_b=01, ADD. Holds until mem_ready. On the mem_ready cycle: ir_we=1, pc_we=1, pc_src=00, go to DECODE.
- DECODE: src_a=0, src_b=11, ADD (BTA into ALUOut). Next state by opcode:
  - LW 100011 / SW 101011 -> MEMADR
  - R 000000 -> EXEC, or JRST if funct=001000
  - BEQ 000100 -> BRANCH
  - ADDI 001000 -> ADDIEX
  - J 000010 / JAL 000011 -> JUMP
  - anything else -> illegal handling
- MEMADR: src_a=1, src_b=10, ADD. Goes to MEMRD (LW) or MEMWR (SW).
- MEMRD: mem_re=1, iord=1; wait for mem_ready, then MEMWB.
- MEMWB: we_reg=1, reg_dst=0, dm2reg=1, done.
- MEMWR: mem_we=1, iord=1; wait for mem_ready, then done.
- EXEC: src_a=1, src_b=00, alu_ctrl decoded from funct. Then ALUWB: we_reg=1, reg_dst=1, done.
- BRANCH: src_a=1, src_b=00, SUB, pc_src=01, pc_we=zero, done.
- ADDIEX: src_a=1, src_b=10, ADD. Then ADDIWB: we_reg=1, reg_dst=0, done.
- JUMP: pc_src=10, pc_we=1. For JAL also we_reg=1 and jal=1. Done.
- JRST: pc_src=11, pc_we=1, jr=1, done.
- "done" means instr_done=1 and next state is FETCH.
- Latencies with zero wait states:
  - LW: 5 cycles
  - SW, R-type, ADDI: 4 cycles
  - BEQ, J, JAL, JR: 3 cycles
- Each cycle of mem_ready=0 adds one cycle.
- funct decode to alu_ctrl:
  - ADD 100000 -> ADD
  - SUB 100010 -> SUB
  - AND 100100 -> AND
  - OR 100101 -> OR
  - SLT 101010 -> SLT
  - SLL 000000 -> SLL
  - SRL 000010 -> SRL
  - any other funct is illegal
- Timeout (TIMEOUT>0):
  - The counter increments each cycle spent in FETCH, MEMRD or MEMWR with mem_ready=0, and clears on state change.
  - When the count reaches TIMEOUT-1 with mem_ready still 0: mem_err pulses, the access is abandoned, and the FSM returns to FETCH.
  - No pc_we, ir_we or we_reg fires on abort, so a fetch retries the same PC.
  - If mem_ready arrives on the terminal count cycle, the access completes and mem_err stays 0.
- mem_re and mem_we are never asserted together.

Optional Feature:
MC_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode or funct sends the FSM to TRAP. TRAP sets illegal=1, holds all enables at 0 and never leaves except on rst.
- Undefined: an illegal opcode or funct goes to FETCH as a NOP, with instr_done pulsed. The PC has already advanced. illegal is tied to 0.

Decomposition:
- Package mc_ctrl_pkg holds:
  - the state enumeration
  - opcode and funct constants
  - the ALU_W alu_ctrl codes: AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, SLL=1000, SRL=1001
  - the pc_src and alu_src_b encodings
- One sub-module, mc_alu_decoder: combinational funct to alu_ctrl decode plus an illegal-funct flag.

Test Plan:
- ADDI (0x20080005), mem_ready always 1 -> instr_done pulses in cycle 4; we_reg=1, reg_dst=0 in cycle 4; pc_we only in cycle 1.
- LW with mem_ready low for 3 cycles in MEMRD -> total latency 8 cycles; dm2reg=1 and we_reg=1 exactly once.
- BEQ with zero=1, then BEQ with zero=0 -> pc_we=1 with pc_src=01 in cycle 3 for the first only; both take 3 cycles.
- TIMEOUT=4, mem_ready held 0 in FETCH -> mem_err pulses on the 4th cycle; FSM re-enters FETCH; pc_we and ir_we stay 0.
- opcode 111111 -> with the macro: illegal=1 sticky, all enables 0 until rst. Without the macro: instr_done in cycle 2, next FETCH.
- rst asserted during MEMWR -> outputs 0 on the next edge, and the FSM starts in FETCH after release.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state encoding, instruction field constants and datapath select codes
package mc_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_JRST, S_TRAP
  } state_e;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_JR  = 6'b001000;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [1:0] PC_ALU = 2'b00;
  localparam logic [1:0] PC_BTA = 2'b01;
  localparam logic [1:0] PC_JTA = 2'b10;
  localparam logic [1:0] PC_RS  = 2'b11;
  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;
endpackage

// File: rtl/mc_ctrl_unit_alu_decoder.sv
// mc_alu_decoder: R-type funct to alu_ctrl, flagging functs with no ALU operation
module mc_alu_decoder
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_W = 4
) (
  input  logic [5:0]       funct_i,
  output logic [ALU_W-1:0] alu_ctrl_o,
  output logic             illegal_o
);
  logic [3:0] code;
  always_comb begin
    illegal_o = 1'b0;
    case (funct_i)
      F_ADD:   code = ALU_ADD;
      F_SUB:   code = ALU_SUB;
      F_AND:   code = ALU_AND;
      F_OR:    code = ALU_OR;
      F_SLT:   code = ALU_SLT;
      F_SLL:   code = ALU_SLL;
      F_SRL:   code = ALU_SRL;
      default: begin
        code      = ALU_ADD;
        illegal_o = 1'b1;
      end
    endcase
  end
  assign alu_ctrl_o = ALU_W'(code);
endmodule

// File: rtl/mc_ctrl_unit.sv
// mc_ctrl_unit: multi-cycle MIPS sequencer with mem_ready handshake and access timeout.
// Define MC_ILLEGAL_TRAP_EN to park illegal instructions in a sticky TRAP state.
module mc_ctrl_unit
  import mc_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int ALU_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_re,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [ALU_W-1:0] alu_ctrl,
  output logic             reg_dst,
  output logic             dm2reg,
  output logic             we_reg,
  output logic             jal,
  output logic             jr,
  output logic             instr_done,
  output logic             mem_err,
  output logic             illegal
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [ALU_W-1:0] A_ADD = ALU_W'(ALU_ADD);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ALU_W-1:0] fn_alu;
  logic fn_bad, wait_st, abort, op_bad;
  mc_alu_decoder #(.ALU_W(ALU_W)) u_dec (
    .funct_i   (funct),
    .alu_ctrl_o(fn_alu),
    .illegal_o (fn_bad)
  );
  assign wait_st = state_q inside {S_FETCH, S_MEMRD, S_MEMWR};
  assign abort   = (TIMEOUT > 0) && wait_st && !mem_ready && (cnt_q == CW'(TIMEOUT - 1));
  // abort re-enters FETCH without a state change, so the counter must clear explicitly
  assign cnt_d   = (wait_st && !mem_ready && !abort) ? cnt_q + CW'(1) : '0;
  assign op_bad  = !(opcode inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_JAL}) ||
                   (opcode == OP_R && funct != F_JR && fn_bad);
  always_comb begin
    state_d    = state_q;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_ctrl   = '0;
    reg_dst    = 1'b0;
    dm2reg     = 1'b0;
    we_reg     = 1'b0;
    jal        = 1'b0;
    jr         = 1'b0;
    instr_done = 1'b0;
    mem_err    = 1'b0;
    illegal    = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_re    = 1'b1;
          alu_src_b = SRCB_4;
          alu_ctrl  = A_ADD;
          ir_we     = mem_ready;
          pc_we     = mem_ready;
          mem_err   = abort;
          state_d   = mem_ready ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          alu_src_b = SRCB_IMM2;
          alu_ctrl  = A_ADD;
          if (op_bad) begin
`ifdef MC_ILLEGAL_TRAP_EN
            state_d = S_TRAP;
`else
            instr_done = 1'b1;
            state_d    = S_FETCH;
`endif
          end else begin
            state_d = (opcode == OP_LW || opcode == OP_SW) ? S_MEMADR :
                      (opcode == OP_R)    ? ((funct == F_JR) ? S_JRST : S_EXEC) :
                      (opcode == OP_BEQ)  ? S_BRANCH :
                      (opcode == OP_ADDI) ? S_ADDIEX : S_JUMP;
          end
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_ctrl  = A_ADD;
          state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          mem_re  = 1'b1;
          iord    = 1'b1;
          mem_err = abort;
          state_d = mem_ready ? S_MEMWB : abort ? S_FETCH : S_MEMRD;
        end
        S_MEMWB: begin
          we_reg     = 1'b1;
          dm2reg     = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_MEMWR: begin
          mem_we     = 1'b1;
          iord       = 1'b1;
          mem_err    = abort;
          instr_done = mem_ready;
          state_d    = (mem_ready || abort) ? S_FETCH : S_MEMWR;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_ctrl  = fn_alu;
          state_d   = S_ALUWB;
        end
        S_ALUWB: begin
          we_reg     = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_ctrl   = ALU_W'(ALU_SUB);
          pc_src     = PC_BTA;
          pc_we      = zero;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_ctrl  = A_ADD;
          state_d   = S_ADDIWB;
        end
        S_ADDIWB: begin
          we_reg     = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_JUMP: begin
          pc_src     = PC_JTA;
          pc_we      = 1'b1;
          we_reg     = (opcode == OP_JAL);
          jal        = (opcode == OP_JAL);
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_JRST: begin
          pc_src     = PC_RS;
          pc_we      = 1'b1;
          jr         = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_TRAP: begin
`ifdef MC_ILLEGAL_TRAP_EN
          illegal = 1'b1;
`endif
        end
        default: state_d = S_FETCH;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_mc_ctrl_unit.sv
// tb_mc_ctrl_unit: table vectors, corner sequences and random instructions against a latency/event model
module tb_mc_ctrl_unit;
  localparam int TO = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [5:0] opcode = '0, funct = '0;
  logic zero = 1'b0, mem_ready = 1'b0;
  logic mem_re, mem_we, iord, ir_we, pc_we, alu_src_a, reg_dst, dm2reg, we_reg, jal, jr;
  logic instr_done, mem_err, illegal;
  logic [1:0] pc_src, alu_src_b;
  logic [3:0] alu_ctrl;
  logic [21:0] outs;
  int checks = 0, fails = 0;
  typedef struct {
    logic [5:0] op, fn;
    logic z;
    int fs, ds, lat;
    logic [31:0] pcwe, we;
  } vec_t;
  vec_t tv[$];
  int o_lat, re_cnt, wr_cnt, iord_cnt, err_cnt, both_cnt, ill_cnt;
  logic [1:0] pcsrc_last;
  logic regdst_w;
  logic [31:0] done_m, pcwe_m, irwe_m, we_m, dm_m, jal_m, jr_m;
  logic [3:0] alu_at[41];
  always #5 clk = ~clk;
  assign outs = {mem_re, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a, alu_src_b, alu_ctrl,
                 reg_dst, dm2reg, we_reg, jal, jr, instr_done, mem_err, illegal};
  mc_ctrl_unit #(.TIMEOUT(TO), .ALU_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_re(mem_re), .mem_we(mem_we), .iord(iord), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .reg_dst(reg_dst),
    .dm2reg(dm2reg), .we_reg(we_reg), .jal(jal), .jr(jr), .instr_done(instr_done),
    .mem_err(mem_err), .illegal(illegal)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  function automatic logic [3:0] exp_alu(input logic [5:0] fn);
    case (fn)
      6'h20: return 4'h2;
      6'h22: return 4'h6;
      6'h24: return 4'h0;
      6'h25: return 4'h1;
      6'h2a: return 4'h7;
      6'h00: return 4'h8;
      6'h02: return 4'h9;
      default: return 4'hf;
    endcase
  endfunction
  // Plays one instruction from FETCH: fs stalls on the fetch, ds stalls on the data access.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z, input int fs, input int ds);
    int fst = fs;
    int dst = ds;
    logic [31:0] b;
    o_lat = 0; re_cnt = 0; wr_cnt = 0; iord_cnt = 0; err_cnt = 0; both_cnt = 0; ill_cnt = 0;
    pcsrc_last = 2'b00; regdst_w = 1'b0;
    done_m = 0; pcwe_m = 0; irwe_m = 0; we_m = 0; dm_m = 0; jal_m = 0; jr_m = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        opcode = op; funct = fn; zero = z;
      end
      if (mem_re || mem_we) begin
        if (!iord) begin mem_ready = (fst == 0); if (fst > 0) fst--; end
        else begin mem_ready = (dst == 0); if (dst > 0) dst--; end
      end else mem_ready = 1'($urandom);
      #1;
      b = 32'(1) << (c - 1);
      if (instr_done) done_m |= b;
      if (pc_we) begin pcwe_m |= b; pcsrc_last = pc_src; end
      if (ir_we) irwe_m |= b;
      if (we_reg) begin we_m |= b; regdst_w = reg_dst; end
      if (dm2reg) dm_m |= b;
      if (jal) jal_m |= b;
      if (jr) jr_m |= b;
      re_cnt += int'(mem_re); wr_cnt += int'(mem_we); iord_cnt += int'(iord);
      err_cnt += int'(mem_err); both_cnt += int'(mem_re && mem_we); ill_cnt += int'(illegal);
      alu_at[c] = alu_ctrl;
      if (instr_done) begin o_lat = c; break; end
    end
  endtask
  // Expected behaviour derived from instruction class and stall counts.
  task automatic check_model(input logic [5:0] op, input logic [5:0] fn, input logic z, input int fs, input int ds);
    logic lw = (op == 6'h23), sw = (op == 6'h2b), beq = (op == 6'h04), addi = (op == 6'h08);
    logic j = (op == 6'h02), jl = (op == 6'h03), isjr = (op == 6'h00 && fn == 6'h08);
    logic r_ok = (op == 6'h00 && !isjr && exp_alu(fn) != 4'hf);
    int f = fs + 1;
    int lat = f + (lw ? 4 + ds : sw ? 3 + ds : (r_ok || addi) ? 3 : (beq || j || jl || isjr) ? 2 : 1);
    logic [31:0] dm = 32'(1) << (lat - 1);
    chk("lat", o_lat, lat);
    chk("done_mask", done_m, dm);
    chk("irwe_mask", irwe_m, 32'(1) << (f - 1));
    chk("pcwe_mask", pcwe_m, (32'(1) << (f - 1)) | ((beq && z) || j || jl || isjr ? dm : 0));
    chk("wereg_mask", we_m, (lw || r_ok || addi || jl) ? dm : 0);
    chk("dm2reg_mask", dm_m, lw ? dm : 0);
    chk("jal_mask", jal_m, jl ? dm : 0);
    chk("jr_mask", jr_m, isjr ? dm : 0);
    chk("pc_src_last", pcsrc_last, (beq && z) ? 1 : (j || jl) ? 2 : isjr ? 3 : 0);
    chk("reg_dst_w", regdst_w, r_ok);
    chk("mem_re_cycles", re_cnt, f + (lw ? ds + 1 : 0));
    chk("mem_we_cycles", wr_cnt, sw ? ds + 1 : 0);
    chk("iord_cycles", iord_cnt, (lw || sw) ? ds + 1 : 0);
    chk("mem_err_cnt", err_cnt, 0);
    chk("re_we_overlap", both_cnt, 0);
    chk("illegal_flag", ill_cnt, 0);
    if (o_lat >= f + 2 && (r_ok || beq || lw || sw || addi))
      chk("alu_exec", alu_at[f + 2], r_ok ? exp_alu(fn) : beq ? 4'h6 : 4'h2);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [5:0] ops[8] = '{6'h00, 6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h02, 6'h03};
    logic [5:0] fns[8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h02, 6'h08};
    logic [31:0] err_m;
    int en, bad_ill, bad_en;
    tv.push_back('{6'h08, 6'h05, 1'b0, 0, 0, 4, 32'h1, 32'h8});
    tv.push_back('{6'h23, 6'h00, 1'b0, 0, 3, 8, 32'h1, 32'h80});
    tv.push_back('{6'h04, 6'h00, 1'b1, 0, 0, 3, 32'h5, 32'h0});
    tv.push_back('{6'h04, 6'h00, 1'b0, 0, 0, 3, 32'h1, 32'h0});
    tv.push_back('{6'h2b, 6'h00, 1'b0, 0, 1, 5, 32'h1, 32'h0});
    tv.push_back('{6'h00, 6'h20, 1'b0, 2, 0, 6, 32'h4, 32'h20});
    tv.push_back('{6'h02, 6'h00, 1'b0, 0, 0, 3, 32'h5, 32'h0});
    tv.push_back('{6'h03, 6'h00, 1'b0, 1, 0, 4, 32'ha, 32'h8});
    tv.push_back('{6'h00, 6'h08, 1'b0, 0, 0, 3, 32'h5, 32'h0});
    tv.push_back('{6'h00, 6'h00, 1'b0, 0, 0, 4, 32'h1, 32'h8});
`ifndef MC_ILLEGAL_TRAP_EN
    tv.push_back('{6'h3f, 6'h00, 1'b0, 0, 0, 2, 32'h1, 32'h0});
    tv.push_back('{6'h00, 6'h3f, 1'b0, 0, 0, 2, 32'h1, 32'h0});
`endif
    rst = 1'b1; mem_ready = 1'b1; opcode = 6'h3f;
    @(posedge clk); #1;
    chk("reset_outs", 32'(outs), 0);
    mem_ready = 1'b0;
    @(posedge clk); #1;
    chk("reset_outs_noready", 32'(outs), 0);
    rst = 1'b0;
    foreach (tv[i]) begin
      run_instr(tv[i].op, tv[i].fn, tv[i].z, tv[i].fs, tv[i].ds);
      chk($sformatf("vec%0d_lat", i), o_lat, tv[i].lat);
      chk($sformatf("vec%0d_pcwe", i), pcwe_m, tv[i].pcwe);
      chk($sformatf("vec%0d_wereg", i), we_m, tv[i].we);
      check_model(tv[i].op, tv[i].fn, tv[i].z, tv[i].fs, tv[i].ds);
    end
    err_m = 0; en = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      if (mem_err) err_m |= 32'(1) << (c - 1);
      if (pc_we || ir_we) en++;
      if (c == 5) chk("timeout_refetch", {mem_re, iord, mem_err}, 3'b100);
    end
    chk("timeout_err_mask", err_m, 32'h8);
    chk("timeout_enables", en, 0);
    run_instr(6'h08, 6'h05, 1'b0, 0, 0);
    check_model(6'h08, 6'h05, 1'b0, 0, 0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) opcode = 6'h2b;
      mem_ready = (c == 1);
      #1;
      if (c == 4) chk("memwr_reached", {mem_we, iord, mem_re}, 3'b110);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_memwr", 32'(outs), 0);
    rst = 1'b0;
    run_instr(6'h08, 6'h05, 1'b0, 0, 0);
    check_model(6'h08, 6'h05, 1'b0, 0, 0);
`ifdef MC_ILLEGAL_TRAP_EN
    bad_ill = 0; bad_en = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) opcode = 6'h3f;
      mem_ready = 1'b1;
      #1;
      if (c >= 3 && !illegal) bad_ill++;
      if (c >= 3 && {mem_re, mem_we, ir_we, pc_we, we_reg, instr_done, jal, jr} != 8'h0) bad_en++;
    end
    chk("trap_sticky", illegal, 1);
    chk("trap_illegal_cycles", bad_ill, 0);
    chk("trap_enables", bad_en, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("trap_rst", 32'(outs), 0);
    rst = 1'b0;
    run_instr(6'h08, 6'h05, 1'b0, 0, 0);
    check_model(6'h08, 6'h05, 1'b0, 0, 0);
`else
    bad_ill = 0; bad_en = 0;
`endif
    for (int n = 0; n < 40; n++) begin
      logic [5:0] op = ops[$urandom_range(0, 7)];
      logic [5:0] fn = fns[$urandom_range(0, 7)];
      logic z = 1'($urandom);
      int fs = $urandom_range(0, TO - 1);
      int ds = $urandom_range(0, TO - 1);
`ifndef MC_ILLEGAL_TRAP_EN
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      if ($urandom_range(0, 7) == 0) fn = 6'($urandom);
`endif
      run_instr(op, fn, z, fs, ds);
      check_model(op, fn, z, fs, ds);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
